// File: rtl/dmem_ram.sv
// Byte-addressable 32-bit data RAM: registered reads, byte-lane writes, sub-word loads, forwarding, zero-init sweep.
// Optional range checking is enabled by defining DMEM_BOUNDS_CHECK_EN.
module dmem_ram #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 2048
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  ready_o,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic [2:0]            rd_size_i,
  input  logic                  rd_signed_i,
  output logic                  rd_valid_o,
  output logic [31:0]           rd_data_o,
  output logic                  rd_err_o,
  input  logic                  wd_en,
  input  logic [ADDR_WIDTH-1:0] wd_addr_i,
  input  logic [2:0]            wd_size_i,
  input  logic [31:0]           wd_data_i,
  output logic                  wd_err_o
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] sweep_cnt;
  logic [31:0]      mem [DEPTH_WORDS];

  logic [IDX_W-1:0] rd_idx, wd_idx;
  logic [1:0]       rd_lane, wd_lane;
  logic             rd_in_range, wd_in_range;
  logic             rd_acc, wd_acc, rd_legal, wd_legal;
  logic [3:0]       wd_be;
  logic [31:0]      wd_bytes;
  logic [31:0]      rd_word, rd_shift, rd_ext;

  function automatic logic aligned(input logic [2:0] size, input logic [1:0] lane);
    case (size)
      3'd1:    return 1'b1;
      3'd2:    return !lane[0];
      3'd4:    return lane == 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  assign ready_o = (state == ST_RUN);

  assign rd_idx  = rd_addr_i[IDX_W+1:2];
  assign wd_idx  = wd_addr_i[IDX_W+1:2];
  assign rd_lane = rd_addr_i[1:0];
  assign wd_lane = wd_addr_i[1:0];

`ifdef DMEM_BOUNDS_CHECK_EN
  localparam logic [ADDR_WIDTH:0] ADDR_LIMIT = (ADDR_WIDTH+1)'(DEPTH_WORDS * 4);
  assign rd_in_range = {1'b0, rd_addr_i} < ADDR_LIMIT;
  assign wd_in_range = {1'b0, wd_addr_i} < ADDR_LIMIT;
`else
  // Upper address bits are deliberately ignored so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{rd_addr_i, wd_addr_i};
  assign rd_in_range = 1'b1;
  assign wd_in_range = 1'b1;
`endif

  assign rd_acc   = rd_en && ready_o;
  assign wd_acc   = wd_en && ready_o;
  assign rd_legal = aligned(rd_size_i, rd_lane) && rd_in_range;
  assign wd_legal = aligned(wd_size_i, wd_lane) && wd_in_range;

  always_comb begin
    wd_be    = 4'b0000;
    wd_bytes = 32'h0;
    case (wd_size_i)
      3'd1: begin
        wd_be    = 4'b0001 << wd_lane;
        wd_bytes = {4{wd_data_i[7:0]}};
      end
      3'd2: begin
        wd_be    = 4'b0011 << wd_lane;
        wd_bytes = {2{wd_data_i[15:0]}};
      end
      3'd4: begin
        wd_be    = 4'b1111;
        wd_bytes = wd_data_i;
      end
      default: ;
    endcase
    if (!(wd_acc && wd_legal)) wd_be = 4'b0000;
  end

  // Lanes written this cycle to the same word override the stored bytes.
  always_comb begin
    rd_word = mem[rd_idx];
    if (wd_idx == rd_idx) begin
      for (int b = 0; b < 4; b++) begin
        if (wd_be[b]) rd_word[8*b +: 8] = wd_bytes[8*b +: 8];
      end
    end
  end

  always_comb begin
    rd_shift = rd_word >> {rd_lane, 3'b000};
    rd_ext   = 32'h0;
    case (rd_size_i)
      3'd1:    rd_ext = {{24{rd_signed_i & rd_shift[7]}}, rd_shift[7:0]};
      3'd2:    rd_ext = {{16{rd_signed_i & rd_shift[15]}}, rd_shift[15:0]};
      3'd4:    rd_ext = rd_shift;
      default: rd_ext = 32'h0;
    endcase
    if (!rd_legal) rd_ext = 32'h0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == ST_INIT) begin
        mem[sweep_cnt] <= 32'h0;
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (wd_be[b]) mem[wd_idx][8*b +: 8] <= wd_bytes[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT;
      sweep_cnt <= '0;
    end else if (state == ST_INIT) begin
      sweep_cnt <= sweep_cnt + 1'b1;
      if (sweep_cnt == IDX_W'(DEPTH_WORDS - 1)) state <= ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid_o <= 1'b0;
      rd_data_o  <= 32'h0;
      rd_err_o   <= 1'b0;
      wd_err_o   <= 1'b0;
    end else begin
      rd_valid_o <= rd_acc;
      wd_err_o   <= wd_acc && !wd_legal;
      if (rd_acc) begin
        rd_data_o <= rd_ext;
        rd_err_o  <= !rd_legal;
      end
    end
  end

endmodule

// File: tb/tb_dmem_ram.sv
// Self-checking bench for dmem_ram: directed plan steps plus random traffic against a byte-array model.
// Honours DMEM_BOUNDS_CHECK_EN the same way the design does.
module tb_dmem_ram;

  localparam int AW    = 32;
  localparam int DW    = 256;
  localparam int BYTES = DW * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ready_o;
  logic        rd_en;
  logic [31:0] rd_addr_i;
  logic [2:0]  rd_size_i;
  logic        rd_signed_i;
  logic        rd_valid_o;
  logic [31:0] rd_data_o;
  logic        rd_err_o;
  logic        wd_en;
  logic [31:0] wd_addr_i;
  logic [2:0]  wd_size_i;
  logic [31:0] wd_data_i;
  logic        wd_err_o;

  int tests    = 0;
  int failures = 0;

  logic [7:0]  model_mem [BYTES];
  bit          model_ready;
  logic [31:0] exp_rd_data;
  logic        exp_rd_err;

  dmem_ram #(.ADDR_WIDTH(AW), .DEPTH_WORDS(DW)) dut (
    .clk(clk), .rst(rst), .ready_o(ready_o),
    .rd_en(rd_en), .rd_addr_i(rd_addr_i), .rd_size_i(rd_size_i), .rd_signed_i(rd_signed_i),
    .rd_valid_o(rd_valid_o), .rd_data_o(rd_data_o), .rd_err_o(rd_err_o),
    .wd_en(wd_en), .wd_addr_i(wd_addr_i), .wd_size_i(wd_size_i), .wd_data_i(wd_data_i),
    .wd_err_o(wd_err_o)
  );

  always #5 clk = ~clk;

  function automatic bit refLegal(input logic [31:0] addr, input logic [2:0] size);
    bit ok;
    case (size)
      3'd1:    ok = 1'b1;
      3'd2:    ok = (addr % 2) == 0;
      3'd4:    ok = (addr % 4) == 0;
      default: ok = 1'b0;
    endcase
`ifdef DMEM_BOUNDS_CHECK_EN
    if (addr >= 32'(BYTES)) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] refRead(input logic [31:0] addr, input logic [2:0] size, input logic sgn);
    int     base = int'(addr % 32'(BYTES));
    int     n    = int'(size);
    longint val  = 0;
    for (int i = 0; i < n; i++) val += longint'(model_mem[base + i]) << (8 * i);
    if (sgn && n < 4 && val >= (longint'(1) << (8 * n - 1))) val -= longint'(1) << (8 * n);
    return val[31:0];
  endfunction

  task automatic refWrite(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] data);
    int base = int'(addr % 32'(BYTES));
    for (int i = 0; i < int'(size); i++) model_mem[base + i] = data[8*i +: 8];
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock with the given read/write requests; the model predicts every output.
  task automatic applyStimulus(input logic re, input logic [31:0] ra, input logic [2:0] rs, input logic rsg,
                               input logic we, input logic [31:0] wa, input logic [2:0] ws,
                               input logic [31:0] wdat);
    logic exp_rv, exp_we;
    rd_en = re; rd_addr_i = ra; rd_size_i = rs; rd_signed_i = rsg;
    wd_en = we; wd_addr_i = wa; wd_size_i = ws; wd_data_i = wdat;
    exp_rv = re && model_ready;
    exp_we = we && model_ready && !refLegal(wa, ws);
    if (we && model_ready && refLegal(wa, ws)) refWrite(wa, ws, wdat);
    if (exp_rv) begin
      if (refLegal(ra, rs)) begin
        exp_rd_data = refRead(ra, rs, rsg);
        exp_rd_err  = 1'b0;
      end else begin
        exp_rd_data = 32'h0;
        exp_rd_err  = 1'b1;
      end
    end
    @(posedge clk); #1;
    checkOutput("rd_valid", {31'b0, rd_valid_o}, {31'b0, exp_rv});
    checkOutput("rd_data", rd_data_o, exp_rd_data);
    checkOutput("rd_err", {31'b0, rd_err_o}, {31'b0, exp_rd_err});
    checkOutput("wd_err", {31'b0, wd_err_o}, {31'b0, exp_we});
    rd_en = 1'b0;
    wd_en = 1'b0;
  endtask

  task automatic doWrite(input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
    applyStimulus(1'b0, 32'h0, 3'd4, 1'b0, 1'b1, a, s, d);
  endtask

  task automatic doRead(input logic [31:0] a, input logic [2:0] s, input logic sg);
    applyStimulus(1'b1, a, s, sg, 1'b0, 32'h0, 3'd4, 32'h0);
  endtask

  task automatic pulseReset();
    rst = 1'b1; rd_en = 1'b0; wd_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_ready = 1'b0;
    exp_rd_data = 32'h0;
    exp_rd_err  = 1'b0;
    for (int i = 0; i < BYTES; i++) model_mem[i] = 8'h00;
  endtask

  // Counts cycles until ready_o rises; optionally pokes requests that must be ignored.
  task automatic waitSweep(input string tag, input bit poke);
    int cnt = 0;
    checkOutput({tag, "_ready_low"}, {31'b0, ready_o}, 32'h0);
    while (ready_o !== 1'b1 && cnt < 2 * DW + 10) begin
      rd_en = poke && cnt < 4; rd_addr_i = 32'h10; rd_size_i = 3'd4; rd_signed_i = 1'b0;
      wd_en = poke && cnt < 4; wd_addr_i = 32'h10 + 32'(cnt); wd_size_i = 3'd2; wd_data_i = 32'hFFFF;
      @(posedge clk); #1;
      cnt++;
      if (poke && cnt <= 5) begin
        checkOutput({tag, "_no_rd_valid"}, {31'b0, rd_valid_o}, 32'h0);
        checkOutput({tag, "_no_wd_err"}, {31'b0, wd_err_o}, 32'h0);
      end
    end
    rd_en = 1'b0; wd_en = 1'b0;
    checkOutput({tag, "_len"}, 32'(cnt), 32'(DW));
    model_ready = 1'b1;
  endtask

  initial begin
    logic [31:0] byte_exp [4];
    logic [31:0] ra, wa;
    logic [2:0]  rs, ws;

    rst = 1'b1; rd_en = 1'b0; rd_addr_i = '0; rd_size_i = 3'd4; rd_signed_i = 1'b0;
    wd_en = 1'b0; wd_addr_i = '0; wd_size_i = 3'd4; wd_data_i = '0;

    // Reset values and the zero-init sweep
    pulseReset();
    checkOutput("rst_rd_valid", {31'b0, rd_valid_o}, 32'h0);
    checkOutput("rst_rd_data", rd_data_o, 32'h0);
    checkOutput("rst_rd_err", {31'b0, rd_err_o}, 32'h0);
    checkOutput("rst_wd_err", {31'b0, wd_err_o}, 32'h0);
    waitSweep("sweep", 1'b1);
    doRead(32'h10, 3'd4, 1'b0);
    checkOutput("init_rd_10", rd_data_o, 32'h0);

    // Sub-word loads
    doWrite(32'h20, 3'd4, 32'h8001F27F);
    byte_exp[0] = 32'h0000007F; byte_exp[1] = 32'hFFFFFFF2;
    byte_exp[2] = 32'h00000001; byte_exp[3] = 32'hFFFFFF80;
    for (int i = 0; i < 4; i++) begin
      doRead(32'h20 + 32'(i), 3'd1, 1'b1);
      checkOutput("byte_signed", rd_data_o, byte_exp[i]);
    end
    doRead(32'h22, 3'd2, 1'b0);
    checkOutput("half_unsigned", rd_data_o, 32'h00008001);
    doRead(32'h22, 3'd2, 1'b1);
    checkOutput("half_signed", rd_data_o, 32'hFFFF8001);

    // Byte-lane writes
    doWrite(32'h40, 3'd4, 32'h11223344);
    doWrite(32'h41, 3'd1, 32'h000000AA);
    doRead(32'h40, 3'd4, 1'b0);
    checkOutput("lane_byte", rd_data_o, 32'h1122AA44);
    doWrite(32'h42, 3'd2, 32'h0000BEEF);
    doRead(32'h40, 3'd4, 1'b0);
    checkOutput("lane_half", rd_data_o, 32'hBEEFAA44);

    // Misalignment and bad size codes
    doWrite(32'h41, 3'd2, 32'h00001234);
    checkOutput("misal_wd_err", {31'b0, wd_err_o}, 32'h1);
    doRead(32'h40, 3'd4, 1'b0);
    checkOutput("misal_wd_pulse_end", {31'b0, wd_err_o}, 32'h0);
    checkOutput("misal_mem_kept", rd_data_o, 32'hBEEFAA44);
    doRead(32'h42, 3'd4, 1'b0);
    checkOutput("misal_rd_err", {31'b0, rd_err_o}, 32'h1);
    checkOutput("misal_rd_data", rd_data_o, 32'h0);
    doRead(32'h40, 3'd3, 1'b0);
    checkOutput("size3_rd_err", {31'b0, rd_err_o}, 32'h1);

    // Forwarding, plus an illegal write that must not be forwarded
    doWrite(32'h50, 3'd4, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h50, 3'd4, 1'b0, 1'b1, 32'h51, 3'd1, 32'h0000005A);
    checkOutput("fwd_data", rd_data_o, 32'hDEAD5AEF);
    applyStimulus(1'b1, 32'h50, 3'd4, 1'b0, 1'b1, 32'h51, 3'd2, 32'h00001111);
    checkOutput("fwd_illegal_wr", rd_data_o, 32'hDEAD5AEF);
    applyStimulus(1'b1, 32'h52, 3'd4, 1'b0, 1'b1, 32'h53, 3'd4, 32'h0);
    checkOutput("both_err_rd", {31'b0, rd_err_o}, 32'h1);
    checkOutput("both_err_wd", {31'b0, wd_err_o}, 32'h1);

    // Range check / address wrap
    doWrite(32'h0, 3'd4, 32'hCAFEF00D);
    doRead(32'(BYTES), 3'd4, 1'b0);
`ifdef DMEM_BOUNDS_CHECK_EN
    checkOutput("oob_rd_err", {31'b0, rd_err_o}, 32'h1);
    checkOutput("oob_rd_data", rd_data_o, 32'h0);
`else
    checkOutput("wrap_rd_err", {31'b0, rd_err_o}, 32'h0);
    checkOutput("wrap_rd_data", rd_data_o, 32'hCAFEF00D);
`endif
    doWrite(32'(BYTES) + 32'h4, 3'd4, 32'h11111111);
    doRead(32'h4, 3'd4, 1'b0);

    // Random traffic concentrated on a few words so forwarding collisions are frequent
    for (int n = 0; n < 400; n++) begin
      ra = 32'($urandom_range(0, 31)); wa = 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) ra = ra + 32'(BYTES) * 32'($urandom_range(1, 3));
      if ($urandom_range(0, 7) == 0) wa = wa + 32'(BYTES) * 32'($urandom_range(1, 3));
      rs = ($urandom_range(0, 9) < 3) ? 3'd1 : ($urandom_range(0, 9) < 5) ? 3'd2 : 3'd4;
      ws = ($urandom_range(0, 9) < 3) ? 3'd1 : ($urandom_range(0, 9) < 5) ? 3'd2 : 3'd4;
      if ($urandom_range(0, 9) == 0) rs = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) ws = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        ra = ra & ~32'(int'(rs) - 1 < 0 ? 0 : (rs == 3'd4 ? 3 : rs == 3'd2 ? 1 : 0));
        wa = wa & ~32'(int'(ws) - 1 < 0 ? 0 : (ws == 3'd4 ? 3 : ws == 3'd2 ? 1 : 0));
      end
      applyStimulus(1'($urandom_range(0, 1)), ra, rs, 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), wa, ws, $urandom);
    end

    // Reset in the middle of a sweep restarts it from the beginning
    pulseReset();
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("mid_ready_low", {31'b0, ready_o}, 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    waitSweep("resweep", 1'b0);
    doRead(32'h50, 3'd4, 1'b0);
    checkOutput("resweep_zero", rd_data_o, 32'h0);
    for (int i = 0; i < 8; i++) doRead(32'($urandom_range(0, DW - 1)) * 4, 3'd4, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
